// File: rtl/udp_bank_pkg.sv
// Shared op encoding and defaults for the edge-sensitive register bank.
// Reserved codes are folded to HOLD once, at config-write time.
package udp_bank_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        LOAD   = 3'd1,
        LOADN  = 3'd2,
        SET    = 3'd3,
        CLR    = 3'd4,
        TOGGLE = 3'd5
    } op_t;

    localparam op_t DEFAULT_RISE_OP = LOAD;
    localparam op_t DEFAULT_FALL_OP = LOADN;

    // Codes 6 and 7 are reserved and must behave as HOLD.
    function automatic op_t decode_op(input logic [2:0] code);
        case (code)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: return op_t'(code);
            default:                            return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/udp_edge_cell.sv
// One edge-sensitive cell: strobe history, per-cell rise/fall ops, state q
// and registered edge pulses. The bank-wide armed flag gates edge detection.
module udp_edge_cell
    import udp_bank_pkg::*;
#(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_armed,
    input  logic             i_strobe,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_cfg_we,
    input  op_t              i_rise_op,
    input  op_t              i_fall_op,
    output logic [WIDTH-1:0] o_q,
    output logic             o_rise_evt,
    output logic             o_fall_evt
);

    logic             r_prev;
    logic [WIDTH-1:0] r_q;
    logic             r_rise_evt;
    logic             r_fall_evt;
    op_t              r_rise_op;
    op_t              r_fall_op;

    logic             w_rise;
    logic             w_fall;
    logic [WIDTH-1:0] w_next_q;

    function automatic logic [WIDTH-1:0] apply_op(
        input op_t              op,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] q
    );
        case (op)
            LOAD:    return d;
            LOADN:   return ~d;
            SET:     return '1;
            CLR:     return '0;
            TOGGLE:  return ~q;
            default: return q;
        endcase
    endfunction

    assign w_rise = i_armed & i_strobe & ~r_prev;
    assign w_fall = i_armed & ~i_strobe & r_prev;

    // Edges use the op registers as they stood before any same-cycle write.
    always_comb begin
        w_next_q = r_q;
        if (w_rise) begin
            w_next_q = apply_op(r_rise_op, i_d, r_q);
        end else if (w_fall) begin
            w_next_q = apply_op(r_fall_op, i_d, r_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= 1'b0;
            r_q        <= INIT;
            r_rise_evt <= 1'b0;
            r_fall_evt <= 1'b0;
            r_rise_op  <= DEFAULT_RISE_OP;
            r_fall_op  <= DEFAULT_FALL_OP;
        end else begin
            r_prev     <= i_strobe;
            r_q        <= w_next_q;
            r_rise_evt <= w_rise;
            r_fall_evt <= w_fall;
            if (i_cfg_we) begin
                r_rise_op <= i_rise_op;
                r_fall_op <= i_fall_op;
            end
        end
    end

    assign o_q        = r_q;
    assign o_rise_evt = r_rise_evt;
    assign o_fall_evt = r_fall_evt;

endmodule

// File: rtl/udp_edge_reg_bank.sv
// Multi-channel edge-capture register bank: holds the bank-wide armed flag and
// the config decode, and replicates one udp_edge_cell per channel.
module udp_edge_reg_bank
    import udp_bank_pkg::*;
#(
    parameter int               CHANNELS = 4,
    parameter int               WIDTH    = 1,
    parameter logic [WIDTH-1:0] INIT     = '1,
    localparam int              CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       strobe,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [2:0]                cfg_rise_op,
    input  logic [2:0]                cfg_fall_op,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       rise_evt,
    output logic [CHANNELS-1:0]       fall_evt
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic r_armed;
    logic w_cfg_ok;
    op_t  w_rise_op;
    op_t  w_fall_op;

    // Armed goes high one cycle after reset release so that cycle only loads prev.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    assign w_cfg_ok  = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
    assign w_rise_op = decode_op(cfg_rise_op);
    assign w_fall_op = decode_op(cfg_fall_op);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cell
        logic w_cell_we;

        assign w_cell_we = w_cfg_ok && (cfg_ch == CH_W'(c));

        udp_edge_cell #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .i_armed    (r_armed),
            .i_strobe   (strobe[c]),
            .i_d        (d[c*WIDTH +: WIDTH]),
            .i_cfg_we   (w_cell_we),
            .i_rise_op  (w_rise_op),
            .i_fall_op  (w_fall_op),
            .o_q        (q[c*WIDTH +: WIDTH]),
            .o_rise_evt (rise_evt[c]),
            .o_fall_evt (fall_evt[c])
        );
    end

endmodule
